// File: rtl/ofdm_cp_insert.sv
// Ping-pong buffered cyclic-prefix insertion: each symbol plays as its last cp_len samples, then all frame_len samples.
// Latency: first CP sample is on o_tdata 2 cycles after the last input handshake; output then runs back-to-back.
// Backpressure: o_tready stalls the read pipeline; i_tready drops only when both banks are full.
// Optional i_tlast framing check with zero padding: define OFDM_CP_INSERT_TLAST_CHECK_EN.
module ofdm_cp_insert #(
  parameter int         MAX_LOG2_LEN      = 8,
  parameter logic [7:0] SR_FRAME_LEN      = 8'h10,
  parameter logic [7:0] SR_CP_LEN         = 8'h11,
  parameter int         DEFAULT_FRAME_LEN = 64,
  parameter int         DEFAULT_CP_LEN    = 16
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic        i_tlast,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_tlast,
  output logic        framing_err
);

  localparam int AW = MAX_LOG2_LEN;
  localparam int LW = MAX_LOG2_LEN + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [LW-1:0] DEF_F   = LW'(DEFAULT_FRAME_LEN);
  localparam logic [LW-1:0] DEF_C   = LW'(DEFAULT_CP_LEN);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

  function automatic logic [LW-1:0] clamp_frame(input logic [31:0] v);
    if (v == 32'd0)             return LW'(1);
    else if (v > 32'(MAX_LEN))  return MAX_LEN;
    else                        return v[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] clamp_max(input logic [31:0] v);
    if (v > 32'(MAX_LEN)) return MAX_LEN;
    else                  return v[LW-1:0];
  endfunction

  logic [LW-1:0] sh_frame_q, sh_frame_d, sh_cp_q, sh_cp_d;
  logic [LW-1:0] cap_frame, cap_cp;
  logic          rdy_en_q, fill_q;
  logic [LW-1:0] wr_cnt_q;
  logic [1:0]    full_q, full_d;
  logic [LW-1:0] bank_frame_q [2];
  logic [LW-1:0] bank_cp_q    [2];
  logic [LW-1:0] wr_frame;
  logic          wr_hs, cnt_last, close, wr_done;
  logic [31:0]   mem_q [2**(AW+1)];

  state_t        state_q, state_d, cur_st;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d, cur_cnt;
  logic          play_q, play_d, other;
  logic [LW-1:0] pf, pc, cp_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_en, rd_last, rd_fin, adv1, load_out;
  logic [31:0]   rd_dat_q, s1_dat;
  logic          s1_vld_q, s1_last_q;
  logic [31:0]   o_dat_q;
  logic          o_vld_q, o_last_q;
  logic          unused_bits;

  // A write landing in the same cycle as a symbol's first sample is seen through the bypass.
  always_comb begin
    sh_frame_d = sh_frame_q;
    sh_cp_d    = sh_cp_q;
    if (set_stb && set_addr == SR_FRAME_LEN) sh_frame_d = clamp_frame(set_data);
    if (set_stb && set_addr == SR_CP_LEN)    sh_cp_d    = clamp_max(set_data);
  end

  assign cap_frame = sh_frame_d;
  assign cap_cp    = (sh_cp_d > sh_frame_d) ? sh_frame_d : sh_cp_d;

  assign i_tready = rdy_en_q && !full_q[fill_q];
  assign wr_hs    = i_tvalid && i_tready;
  assign wr_frame = (wr_cnt_q == '0) ? cap_frame : bank_frame_q[fill_q];
  assign cnt_last = (wr_cnt_q == wr_frame - LW'(1));
  assign wr_done  = wr_hs && close;

  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[fill_q] = 1'b1;
    if (rd_fin)  full_d[play_q] = 1'b0;
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      rdy_en_q   <= 1'b0;
      fill_q     <= 1'b0;
      wr_cnt_q   <= '0;
      full_q     <= '0;
      sh_frame_q <= DEF_F;
      sh_cp_q    <= DEF_C;
      for (int b = 0; b < 2; b++) begin
        bank_frame_q[b] <= DEF_F;
        bank_cp_q[b]    <= DEF_C;
      end
    end else begin
      rdy_en_q   <= 1'b1;
      sh_frame_q <= sh_frame_d;
      sh_cp_q    <= sh_cp_d;
      full_q     <= full_d;
      if (wr_hs) begin
        if (wr_cnt_q == '0) begin
          bank_frame_q[fill_q] <= cap_frame;
          bank_cp_q[fill_q]    <= cap_cp;
        end
        if (close) begin
          wr_cnt_q <= '0;
          fill_q   <= ~fill_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (wr_hs) mem_q[{fill_q, wr_cnt_q[AW-1:0]}] <= i_tdata;
  end

  always_ff @(posedge ce_clk) begin
    if (rd_en) rd_dat_q <= mem_q[{play_q, rd_addr}];
  end

  assign other    = ~play_q;
  assign pf       = bank_frame_q[play_q];
  assign pc       = bank_cp_q[play_q];
  assign load_out = s1_vld_q && (!o_vld_q || o_tready);
  assign adv1     = !s1_vld_q || load_out;

  // IDLE with a full bank behaves as the first CP/BODY beat so the first read issues immediately.
  assign cur_st  = (state_q == S_IDLE && full_q[play_q]) ? ((pc == '0) ? S_BODY : S_CP) : state_q;
  assign cur_cnt = (state_q == S_IDLE) ? '0 : rd_cnt_q;

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      play_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      play_q   <= play_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    play_d   = play_q;
    rd_fin   = 1'b0;
    if (adv1) begin
      case (cur_st)
        S_CP: begin
          state_d  = (cur_cnt == pc - LW'(1)) ? S_BODY : S_CP;
          rd_cnt_d = (cur_cnt == pc - LW'(1)) ? '0 : cur_cnt + LW'(1);
        end
        S_BODY: begin
          if (cur_cnt == pf - LW'(1)) begin
            rd_fin   = 1'b1;
            play_d   = other;
            rd_cnt_d = '0;
            if (full_q[other]) state_d = (bank_cp_q[other] == '0) ? S_BODY : S_CP;
            else               state_d = S_IDLE;
          end else begin
            state_d  = S_BODY;
            rd_cnt_d = cur_cnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp_addr = pf - pc + cur_cnt;

  always_comb begin
    rd_en   = adv1 && (cur_st != S_IDLE);
    rd_addr = (cur_st == S_CP) ? cp_addr[AW-1:0] : cur_cnt[AW-1:0];
    rd_last = (cur_st == S_BODY) && (cur_cnt == pf - LW'(1));
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      o_vld_q   <= 1'b0;
      o_last_q  <= 1'b0;
      o_dat_q   <= '0;
    end else begin
      if (adv1) begin
        s1_vld_q  <= rd_en;
        s1_last_q <= rd_last;
      end
      if (!o_vld_q || o_tready) begin
        o_vld_q  <= s1_vld_q;
        o_last_q <= s1_vld_q && s1_last_q;
        if (s1_vld_q) o_dat_q <= s1_dat;
      end
    end
  end

`ifdef OFDM_CP_INSERT_TLAST_CHECK_EN
  logic          err_q, s1_zero_q;
  logic [LW-1:0] bank_vlen_q [2];

  // An early i_tlast closes the bank; reads beyond the written length play as zeros.
  assign close = cnt_last || i_tlast;

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      err_q     <= 1'b0;
      s1_zero_q <= 1'b0;
      for (int b = 0; b < 2; b++) bank_vlen_q[b] <= DEF_F;
    end else begin
      if (wr_hs && (i_tlast != cnt_last)) err_q <= 1'b1;
      if (wr_done) bank_vlen_q[fill_q] <= wr_cnt_q + LW'(1);
      if (adv1) s1_zero_q <= ({1'b0, rd_addr} >= bank_vlen_q[play_q]);
    end
  end

  assign s1_dat      = s1_zero_q ? 32'd0 : rd_dat_q;
  assign framing_err = err_q;
`else
  assign close       = cnt_last;
  assign s1_dat      = rd_dat_q;
  assign framing_err = 1'b0;
`endif

  assign unused_bits = ^{cp_addr[AW], i_tlast};

  assign o_tdata  = o_dat_q;
  assign o_tvalid = o_vld_q;
  assign o_tlast  = o_last_q;

endmodule

// File: doc/ofdm_cp_insert.md
Name: ofdm_cp_insert

Overview:
- Transmit-side counterpart of the Schmidl-Cox receiver / periodic framer chain.
- Takes time-domain OFDM symbols (IFFT output) as a continuous AXI-Stream of complex samples and emits each symbol prefixed by its cyclic prefix: the last cp_len samples, then all frame_len samples.
- Sits between the IFFT and the radio-side TX path inside a noc_block.
- Uses ping-pong symbol buffers so output runs at full rate while the next symbol loads.

Parameters:
- MAX_LOG2_LEN, 8, log2 of the largest supported frame_len; each bank holds 2^MAX_LOG2_LEN samples.
- SR_FRAME_LEN, 8'h10, settings address for frame_len (FFT size).
- SR_CP_LEN, 8'h11, settings address for cp_len.
- DEFAULT_FRAME_LEN, 64, frame_len value after reset.
- DEFAULT_CP_LEN, 16, cp_len value after reset.

Ports:
- ce_clk  in  1  block clock; all logic is in this single domain.
- ce_rst_n  in  1  asynchronous, active-low reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  32  input sample, {I[15:0], Q[15:0]}.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- i_tlast  in  1  end-of-symbol marker; used only when the optional feature is compiled in.
- o_tdata  out  32  output sample.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- o_tlast  out  1  last sample of each prefixed symbol.
- framing_err  out  1  sticky input framing error; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: i_tready=0 during reset and 1 from the first cycle after reset; o_tvalid=0, o_tlast=0, o_tdata=0, framing_err=0.
- Reset also sets frame_len=DEFAULT_FRAME_LEN, cp_len=DEFAULT_CP_LEN and marks both banks empty. Deasserting reset mid-symbol discards all buffered data; there is no partial output.
- Settings:
  - A write on set_stb with a matching address updates a shadow register.
  - Shadow values are copied into the active config when the first sample of a new input symbol is accepted. A symbol already loading or playing keeps the config it captured.
  - frame_len clamp: 0 becomes 1; values above 2^MAX_LOG2_LEN become 2^MAX_LOG2_LEN.
  - cp_len clamp: values above frame_len become frame_len.
- Write side:
  - wr_cnt counts accepted samples into the fill bank.
  - On wr_cnt == frame_len-1 with a handshake, the bank is marked full and the fill pointer toggles.
  - i_tready = fill bank not full.
- Read side, states IDLE -> CP -> BODY -> IDLE/CP:
  - IDLE: move to CP when the play bank is full; if cp_len == 0, go directly to BODY.
  - CP: read addresses frame_len-cp_len .. frame_len-1.
  - BODY: read addresses 0 .. frame_len-1. On the final handshake, mark the bank empty and toggle the play pointer. If the other bank is full, go straight to CP (or BODY when its cp_len == 0) with no idle cycle; otherwise go to IDLE.
- RAM read latency is 1 cycle and the output stage is registered.
- Handshake: with o_tready held high, samples come out back-to-back at one per cycle, both within a symbol and across symbol boundaries. When o_tready=0, o_tdata, o_tvalid and o_tlast stay stable until accepted.
- o_tlast is high only on the final BODY sample; there are exactly frame_len+cp_len beats per symbol.
- Latency: the first CP sample appears on o_tdata 2 cycles after the handshake of the last input sample of a symbol, when the output is idle.
- Simultaneous events: one bank filling while the other plays is legal. A setting written in the same cycle as a symbol's first input sample takes effect for that symbol.
- Throughput: input is stalled only when both banks are full.

Optional Feature:
- Macro OFDM_CP_INSERT_TLAST_CHECK_EN.
- With it defined:
  - i_tlast is checked against wr_cnt.
  - i_tlast=1 when wr_cnt != frame_len-1, or i_tlast=0 on the frame_len-th sample, sets framing_err (sticky until reset).
  - On an early i_tlast, the symbol is closed at that point and the missing samples play out as zeros, so output length stays frame_len+cp_len.
- Without it: i_tlast is ignored, framing_err is tied 0, and framing is purely counter-based.

Test Plan:
- Defaults 64/16, input ramp 0..127 (two symbols), o_tready=1 -> 160 beats: 48..63, 0..63, 112..127, 64..127; o_tlast on beats 79 and 159; no gap between the two symbols.
- Random o_tready (50%) on the same ramp -> identical sample sequence; o_tdata stable while o_tvalid=1 and o_tready=0; i_tready drops only when both banks are full.
- cp_len=0, frame_len=8 -> output equals input in groups of 8, with o_tlast every 8th beat.
- Write frame_len=32, cp_len=8 while symbol 1 (64/16) is loading -> symbol 1 is 80 beats; symbol 2 is 40 beats starting with input samples 24..31.
- Set cp_len=100 with frame_len=64, and frame_len=1000 with MAX_LOG2_LEN=8 -> cp clamps to 64 (128-beat symbol); frame clamps to 256.
- Assert ce_rst_n low mid-BODY -> next cycle o_tvalid=0; after release, a fresh 64/16 symbol plays correctly. With OFDM_CP_INSERT_TLAST_CHECK_EN defined, i_tlast on the 10th sample -> framing_err=1, and 54 zero samples are padded into the output.
